// File: rtl/agex_stage.sv
// -----------------------------------------------------------------------------
// agex_stage
//
// Address-generation / execute stage of the LC-3b pipeline. Captures the
// decode stage's AGEX-bound outputs into the AGEX latches, computes the memory
// address and the ALU/shift result, registers them into the MEM latches and
// returns the AGEX-stage hazard signals to decode and fetch.
//
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   ld_agex           load enable for the AGEX latches
//   mem_stall         MEM stage stalled; MEM latches hold
//   de_npc, de_ir     NPC / IR of the instruction leaving decode
//   agex_sr1/sr2      register operands
//   agex_drid_new     destination register ID
//   agex_cs[19:0]     control bits (agex_cs[k] = control-store bit k+3)
//   agex_cc           architectural NZP
//   agex_v            instruction valid (0 = bubble)
//   agex_drid_old     AGEX.DRID latch
//   v_agex_ld_reg/ld_cc/br_stall  hazard outputs, qualified by AGEX.V
//   mem_*             MEM pipeline latches
//
// Configuration:
//   AGEX_SHF_EN  defined   -> full SHF unit (LSHF / RSHFL / RSHFA by IR[3:0])
//                undefined -> SHF result is AGEX.SR1 unshifted
// -----------------------------------------------------------------------------
module agex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_agex,
  input  logic        mem_stall,
  input  logic [15:0] de_npc,
  input  logic [15:0] de_ir,
  input  logic [15:0] agex_sr1,
  input  logic [15:0] agex_sr2,
  input  logic [2:0]  agex_drid_new,
  input  logic [19:0] agex_cs,
  input  logic [2:0]  agex_cc,
  input  logic        agex_v,
  output logic [2:0]  agex_drid_old,
  output logic        v_agex_ld_reg,
  output logic        v_agex_ld_cc,
  output logic        v_agex_br_stall,
  output logic [15:0] mem_address,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_npc,
  output logic [15:0] mem_ir,
  output logic [10:0] mem_cs,
  output logic [2:0]  mem_drid,
  output logic [2:0]  mem_cc,
  output logic        mem_v
);

  // ALUK encodings
  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_XOR   = 2'b10;
  localparam logic [1:0] ALUK_PASSB = 2'b11;

  // ---------------------------------------------------------------------------
  // AGEX latches
  // ---------------------------------------------------------------------------
  logic [15:0] agex_npc_q;
  logic [15:0] agex_ir_q;
  logic [15:0] agex_sr1_q;
  logic [15:0] agex_sr2_q;
  logic [2:0]  agex_drid_q;
  logic [19:0] agex_cs_q;
  logic [2:0]  agex_cc_q;
  logic        agex_v_q;

  // NOTE: sequential state uses non-blocking assignments so every latch samples
  // the pre-edge values of its sources regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every pipeline latch is reset so that a flushed instruction can
    // never leave behind a stale valid bit or stale data on the outputs.
    if (!rst_n) begin
      agex_npc_q  <= '0;
      agex_ir_q   <= '0;
      agex_sr1_q  <= '0;
      agex_sr2_q  <= '0;
      agex_drid_q <= '0;
      agex_cs_q   <= '0;
      agex_cc_q   <= '0;
      agex_v_q    <= 1'b0;
    end else if (ld_agex) begin
      agex_npc_q  <= de_npc;
      agex_ir_q   <= de_ir;
      agex_sr1_q  <= agex_sr1;
      agex_sr2_q  <= agex_sr2;
      agex_drid_q <= agex_drid_new;
      agex_cs_q   <= agex_cs;
      agex_cc_q   <= agex_cc;
      // A decode dependency stall arrives with agex_v=0 and becomes a bubble.
      agex_v_q    <= agex_v;
    end
  end

  // ---------------------------------------------------------------------------
  // Control field decode
  // ---------------------------------------------------------------------------
  logic       addr1mux;
  logic [1:0] addr2mux;
  logic       lshf1;
  logic       addressmux;
  logic       sr2mux;
  logic [1:0] aluk;
  logic       resultmux;

  assign addr1mux   = agex_cs_q[0];
  assign addr2mux   = agex_cs_q[2:1];
  assign lshf1      = agex_cs_q[3];
  assign addressmux = agex_cs_q[4];
  assign sr2mux     = agex_cs_q[5];
  assign aluk       = agex_cs_q[7:6];
  assign resultmux  = agex_cs_q[8];

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  logic [15:0] addr1;
  logic [15:0] addr2;
  logic [15:0] addr2_shf;
  logic [15:0] address;

  assign addr1 = addr1mux ? agex_sr1_q : agex_npc_q;

  // NOTE: a combinational block assigns its output on every path (default
  // first) so no latch is inferred.
  always_comb begin
    addr2 = 16'h0000;
    case (addr2mux)
      2'b00: addr2 = 16'h0000;
      2'b01: addr2 = {{10{agex_ir_q[5]}},  agex_ir_q[5:0]};
      2'b10: addr2 = {{7{agex_ir_q[8]}},   agex_ir_q[8:0]};
      2'b11: addr2 = {{5{agex_ir_q[10]}},  agex_ir_q[10:0]};
      default: addr2 = 16'h0000;
    endcase
  end

  assign addr2_shf = lshf1 ? {addr2[14:0], 1'b0} : addr2;

  // ADDRESSMUX=0 forms the TRAP vector-table address.
  assign address = addressmux ? (addr1 + addr2_shf)
                              : {7'b0, agex_ir_q[7:0], 1'b0};

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  assign alu_b = sr2mux ? {{11{agex_ir_q[4]}}, agex_ir_q[4:0]} : agex_sr2_q;

  always_comb begin
    alu_result = 16'h0000;
    case (aluk)
      ALUK_ADD:   alu_result = agex_sr1_q + alu_b;
      ALUK_AND:   alu_result = agex_sr1_q & alu_b;
      ALUK_XOR:   alu_result = agex_sr1_q ^ alu_b;
      ALUK_PASSB: alu_result = alu_b;
      default:    alu_result = 16'h0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SHF unit
  // ---------------------------------------------------------------------------
  logic [15:0] shf_result;

`ifdef AGEX_SHF_EN
  always_comb begin
    shf_result = agex_sr1_q;
    if (!agex_ir_q[4]) begin
      shf_result = agex_sr1_q << agex_ir_q[3:0];
    end else if (!agex_ir_q[5]) begin
      shf_result = agex_sr1_q >> agex_ir_q[3:0];
    end else begin
      shf_result = 16'($signed(agex_sr1_q) >>> agex_ir_q[3:0]);
    end
  end
`else
  assign shf_result = agex_sr1_q;
`endif

  logic [15:0] exec_result;
  assign exec_result = resultmux ? alu_result : shf_result;

  // ---------------------------------------------------------------------------
  // MEM latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address    <= '0;
      mem_alu_result <= '0;
      mem_npc        <= '0;
      mem_ir         <= '0;
      mem_cs         <= '0;
      mem_drid       <= '0;
      mem_cc         <= '0;
      mem_v          <= 1'b0;
    end else if (!mem_stall) begin
      mem_address    <= address;
      mem_alu_result <= exec_result;
      mem_npc        <= agex_npc_q;
      mem_ir         <= agex_ir_q;
      mem_cs         <= agex_cs_q[19:9];
      mem_drid       <= agex_drid_q;
      mem_cc         <= agex_cc_q;
      mem_v          <= agex_v_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard outputs: a bubble never asserts any of them.
  // ---------------------------------------------------------------------------
  assign agex_drid_old   = agex_drid_q;
  assign v_agex_ld_reg   = agex_v_q & agex_cs_q[18];
  assign v_agex_ld_cc    = agex_v_q & agex_cs_q[19];
  assign v_agex_br_stall = agex_v_q & agex_cs_q[12];

endmodule

// File: tb/tb_agex_stage.sv
// -----------------------------------------------------------------------------
// tb_agex_stage
//
// Self-checking bench for agex_stage. Each issued instruction pushes its
// expected MEM-latch contents onto a scoreboard queue; a monitor pops and
// compares whenever the MEM latches load a valid instruction. Scenario tasks
// add their own inline checks (reset, stall, bubbles, hazards).
// -----------------------------------------------------------------------------
module tb_agex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_agex;
  logic        mem_stall;
  logic [15:0] de_npc;
  logic [15:0] de_ir;
  logic [15:0] agex_sr1;
  logic [15:0] agex_sr2;
  logic [2:0]  agex_drid_new;
  logic [19:0] agex_cs;
  logic [2:0]  agex_cc;
  logic        agex_v;
  logic [2:0]  agex_drid_old;
  logic        v_agex_ld_reg;
  logic        v_agex_ld_cc;
  logic        v_agex_br_stall;
  logic [15:0] mem_address;
  logic [15:0] mem_alu_result;
  logic [15:0] mem_npc;
  logic [15:0] mem_ir;
  logic [10:0] mem_cs;
  logic [2:0]  mem_drid;
  logic [2:0]  mem_cc;
  logic        mem_v;

  agex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ld_agex         (ld_agex),
    .mem_stall       (mem_stall),
    .de_npc          (de_npc),
    .de_ir           (de_ir),
    .agex_sr1        (agex_sr1),
    .agex_sr2        (agex_sr2),
    .agex_drid_new   (agex_drid_new),
    .agex_cs         (agex_cs),
    .agex_cc         (agex_cc),
    .agex_v          (agex_v),
    .agex_drid_old   (agex_drid_old),
    .v_agex_ld_reg   (v_agex_ld_reg),
    .v_agex_ld_cc    (v_agex_ld_cc),
    .v_agex_br_stall (v_agex_br_stall),
    .mem_address     (mem_address),
    .mem_alu_result  (mem_alu_result),
    .mem_npc         (mem_npc),
    .mem_ir          (mem_ir),
    .mem_cs          (mem_cs),
    .mem_drid        (mem_drid),
    .mem_cc          (mem_cc),
    .mem_v           (mem_v)
  );

  always #5 clk = ~clk;

`ifdef AGEX_SHF_EN
  localparam logic [15:0] E_RSHFA = 16'hF801;
  localparam logic [15:0] E_RSHFL = 16'h0801;
  localparam logic [15:0] E_LSHF  = 16'h0100;
`else
  localparam logic [15:0] E_RSHFA = 16'h8010;
  localparam logic [15:0] E_RSHFL = 16'h8010;
  localparam logic [15:0] E_LSHF  = 16'h8010;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [15:0] alu;
    logic [15:0] npc;
    logic [15:0] ir;
    logic [2:0]  drid;
    logic [2:0]  cc;
    logic [10:0] cs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic mem_loaded = 1'b0;

  // The bench knows from its own stimulus on which edges MEM loads.
  always @(posedge clk) mem_loaded <= rst_n && !mem_stall;

  always @(negedge clk) begin
    if (mem_loaded && mem_v === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: valid MEM output ir=%h with no expected entry", mem_ir);
      end else begin
        mon_e = sb.pop_front();
        if (mem_address !== mon_e.addr) begin
          failures++;
          $display("FAIL sb_address ir=%h: got %h expected %h", mon_e.ir, mem_address, mon_e.addr);
        end
        checks++;
        if (mem_alu_result !== mon_e.alu) begin
          failures++;
          $display("FAIL sb_alu ir=%h: got %h expected %h", mon_e.ir, mem_alu_result, mon_e.alu);
        end
        checks++;
        if ({mem_npc, mem_ir, mem_drid, mem_cc, mem_cs} !==
            {mon_e.npc, mon_e.ir, mon_e.drid, mon_e.cc, mon_e.cs}) begin
          failures++;
          $display("FAIL sb_fields: got npc=%h ir=%h drid=%0d cc=%b cs=%h expected npc=%h ir=%h drid=%0d cc=%b cs=%h",
                   mem_npc, mem_ir, mem_drid, mem_cc, mem_cs,
                   mon_e.npc, mon_e.ir, mon_e.drid, mon_e.cc, mon_e.cs);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one valid instruction for one ld edge, then drop back to a bubble.
  task automatic issue(input logic [15:0] npc, input logic [15:0] ir,
                       input logic [15:0] sr1, input logic [15:0] sr2,
                       input logic [2:0] drid, input logic [19:0] cs,
                       input logic [2:0] cc,
                       input logic [15:0] e_addr, input logic [15:0] e_alu);
    exp_t e;
    de_npc        = npc;
    de_ir         = ir;
    agex_sr1      = sr1;
    agex_sr2      = sr2;
    agex_drid_new = drid;
    agex_cs       = cs;
    agex_cc       = cc;
    agex_v        = 1'b1;
    ld_agex       = 1'b1;
    e.addr = e_addr;
    e.alu  = e_alu;
    e.npc  = npc;
    e.ir   = ir;
    e.drid = drid;
    e.cc   = cc;
    e.cs   = cs[19:9];
    sb.push_back(e);
    @(posedge clk);
    #1;
    agex_v = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (mem_v !== 1'b0) begin
      failures++;
      $display("FAIL %s_mem_v: got %b expected 0", name, mem_v);
    end
    checks++;
    if ({v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall, agex_drid_old} !== 6'b0) begin
      failures++;
      $display("FAIL %s_hazard: got ld_reg=%b ld_cc=%b br_stall=%b drid_old=%0d expected all 0",
               name, v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall, agex_drid_old);
    end
    checks++;
    if ({mem_address, mem_alu_result, mem_npc, mem_ir, mem_cs, mem_drid, mem_cc} !== '0) begin
      failures++;
      $display("FAIL %s_data: got addr=%h alu=%h npc=%h ir=%h cs=%h drid=%0d cc=%b expected all 0",
               name, mem_address, mem_alu_result, mem_npc, mem_ir, mem_cs, mem_drid, mem_cc);
    end
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_imm();
    // ADD R1,R2,#5 : SR1=3 -> 8 ; ADDRESSMUX=0 gives zext(0xA5)<<1
    issue(16'h3000, 16'h12A5, 16'h0003, 16'h0000, 3'd1, 20'h0C0120, 3'b010,
          16'h014A, 16'h0008);
    @(negedge clk);
    checks++;
    if (mem_v !== 1'b0) begin
      failures++;
      $display("FAIL add_latency: mem_v got %b expected 0 after one edge", mem_v);
    end
    tick(1);
    @(negedge clk);
    checks++;
    if ({mem_v, mem_alu_result, mem_drid} !== {1'b1, 16'h0008, 3'd1}) begin
      failures++;
      $display("FAIL add_result: got v=%b alu=%h drid=%0d expected v=1 alu=0008 drid=1",
               mem_v, mem_alu_result, mem_drid);
    end
  endtask

  task automatic test_addr_gen();
    // LDW R3,R4,#-2 (LSHF1): 0x4000 - 4
    issue(16'h3002, 16'h673E, 16'h4000, 16'h1234, 3'd3, 20'h0401DB, 3'b001,
          16'h3FFC, 16'h1234);
    // TRAP x25 -> vector 0x004A, PASSB of SR2
    issue(16'h3004, 16'hF025, 16'h0000, 16'hBEEF, 3'd7, 20'h0411C0, 3'b100,
          16'h004A, 16'hBEEF);
    // BR offset9 = -3 from NPC 0x3010, LSHF1
    issue(16'h3010, 16'h0FFD, 16'h0000, 16'h0000, 3'd0, 20'h00101C, 3'b010,
          16'h300A, 16'h0000);
    // JSR offset11 = +10 from NPC 0x3020, LSHF1
    issue(16'h3020, 16'h480A, 16'h0000, 16'h0000, 3'd7, 20'h04101E, 3'b010,
          16'h3034, 16'h0000);
    // JMP R7: SR1 + 0, shift amount 0 passes SR1
    issue(16'h3030, 16'hC1C0, 16'h5555, 16'h0000, 3'd0, 20'h001011, 3'b001,
          16'h5555, 16'h5555);
    tick(1);
  endtask

  task automatic test_alu();
    // AND / XOR register forms
    issue(16'h3040, 16'h5283, 16'hF0F0, 16'h3C3C, 3'd1, 20'h0C0140, 3'b010,
          16'h0106, 16'h3030);
    issue(16'h3042, 16'h9283, 16'hF0F0, 16'h3C3C, 3'd1, 20'h0C0180, 3'b100,
          16'h0106, 16'hCCCC);
    // ADD immediate wraps: 0xFFFF + (-1) = 0xFFFE
    issue(16'h3044, 16'h12BF, 16'hFFFF, 16'h0000, 3'd1, 20'h0C0120, 3'b100,
          16'h017E, 16'hFFFE);
    tick(1);
  endtask

  task automatic test_back_to_back();
    // Shifts on SR1=0x8010 by 4, then RSHFA by 0
    issue(16'h3050, 16'hD474, 16'h8010, 16'h0000, 3'd2, 20'h040000, 3'b100,
          16'h00E8, E_RSHFA);
    issue(16'h3052, 16'hD454, 16'h8010, 16'h0000, 3'd2, 20'h040000, 3'b100,
          16'h00A8, E_RSHFL);
    issue(16'h3054, 16'hD444, 16'h8010, 16'h0000, 3'd2, 20'h040000, 3'b100,
          16'h0088, E_LSHF);
    issue(16'h3056, 16'hD470, 16'h8010, 16'h0000, 3'd2, 20'h040000, 3'b100,
          16'h00E0, 16'h8010);
    tick(1);
  endtask

  task automatic test_stall();
    // Y: ADD R2,R2,#5 with SR1=0x10 ; X: AND R1 (stays in AGEX during stall)
    issue(16'h3100, 16'h14A5, 16'h0010, 16'h0000, 3'd2, 20'h0C0120, 3'b001,
          16'h014A, 16'h0015);
    issue(16'h3102, 16'h5283, 16'hF0F0, 16'h3C3C, 3'd1, 20'h0C0140, 3'b010,
          16'h0106, 16'h3030);
    mem_stall = 1'b1;
    ld_agex   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mem_v, mem_address, mem_alu_result, mem_ir, mem_drid} !==
          {1'b1, 16'h014A, 16'h0015, 16'h14A5, 3'd2}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b addr=%h alu=%h ir=%h drid=%0d expected v=1 addr=014a alu=0015 ir=14a5 drid=2",
                 i, mem_v, mem_address, mem_alu_result, mem_ir, mem_drid);
      end
      checks++;
      if ({v_agex_ld_reg, agex_drid_old} !== {1'b1, 3'd1}) begin
        failures++;
        $display("FAIL stall_agex[%0d]: got ld_reg=%b drid_old=%0d expected ld_reg=1 drid_old=1",
                 i, v_agex_ld_reg, agex_drid_old);
      end
    end
    mem_stall = 1'b0;
    ld_agex   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_v !== 1'b0) begin
      failures++;
      $display("FAIL stall_dup: mem_v got %b expected 0 after released instruction", mem_v);
    end
    #2;
  endtask

  task automatic test_bubble_hazard();
    issue(16'h3200, 16'h1234, 16'h0000, 16'h0000, 3'd5, 20'h0C1000, 3'b100,
          16'h0068, 16'h0000);
    checks++;
    if ({v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall} !== 3'b111) begin
      failures++;
      $display("FAIL hazard_valid: got %b%b%b expected 111",
               v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall);
    end
    // Same control bits, agex_v=0 -> bubble
    tick(1);
    checks++;
    if ({v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall} !== 3'b000) begin
      failures++;
      $display("FAIL hazard_bubble: got %b%b%b expected 000",
               v_agex_ld_reg, v_agex_ld_cc, v_agex_br_stall);
    end
    tick(1);
  endtask

  task automatic test_reset_mid();
    issue(16'h3300, 16'h12A5, 16'h0001, 16'h0000, 3'd1, 20'h0C0120, 3'b010,
          16'h014A, 16'h0006);
    issue(16'h3302, 16'h14A5, 16'h0002, 16'h0000, 3'd2, 20'h0C0120, 3'b010,
          16'h014A, 16'h0007);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    sb.delete();
    agex_v = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset_priority");
    agex_v = 1'b0;
    rst_n  = 1'b1;
    issue(16'h3400, 16'h12A5, 16'h0004, 16'h0000, 3'd1, 20'h0C0120, 3'b001,
          16'h014A, 16'h0009);
    checks++;
    if (mem_v !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_ld: mem_v got %b expected 0", mem_v);
    end
    tick(1);
    checks++;
    if (mem_v !== 1'b1) begin
      failures++;
      $display("FAIL reset_second_ld: mem_v got %b expected 1", mem_v);
    end
    tick(1);
  endtask

  initial begin
    rst_n         = 1'b0;
    ld_agex       = 1'b1;
    mem_stall     = 1'b0;
    de_npc        = '0;
    de_ir         = '0;
    agex_sr1      = '0;
    agex_sr2      = '0;
    agex_drid_new = '0;
    agex_cs       = '0;
    agex_cc       = '0;
    agex_v        = 1'b0;

    test_reset();
    test_add_imm();
    test_addr_gen();
    test_alu();
    test_back_to_back();
    test_stall();
    test_bubble_hazard();
    test_reset_mid();

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: %0d expected entries never reached MEM, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agex_stage.md
# agex_stage

Address-generation/execute stage of the LC-3b pipeline. It is the consumer of the decode stage's AGEX-bound outputs. It captures them into the AGEX pipeline latches and computes the memory address and the ALU/shift result. It registers the results into the MEM pipeline latches and returns the AGEX-stage hazard signals (load-register, load-CC, destination ID, branch stall) to decode and fetch.

## Interface
- No parameters.
- clk  in  1  single pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_agex  in  1  load enable for AGEX latches (from decode).
- mem_stall  in  1  MEM stage stalled; freezes the MEM latches.
- de_npc, de_ir  in  16 each  NPC/IR of the instruction in decode.
- agex_sr1, agex_sr2  in  16 each  register operands.
- agex_drid_new  in  3  destination register ID.
- agex_cs  in  20  control bits; agex_cs[k] = control-store bit k+3.
- agex_cc  in  3  architectural NZP.
- agex_v  in  1  instruction valid (0 = bubble).
- agex_drid_old  out  3  AGEX.DRID latch.
- v_agex_ld_reg  out  1  AGEX.V & LD.REG (agex_cs[18]).
- v_agex_ld_cc  out  1  AGEX.V & LD.CC (agex_cs[19]).
- v_agex_br_stall  out  1  AGEX.V & BR.STALL (agex_cs[12]).
- mem_address, mem_alu_result, mem_npc, mem_ir  out  16 each  MEM latches.
- mem_cs  out  11  MEM.CS, equal to the latched AGEX.CS[19:9] (control-store bits 12–22).
- mem_drid  out  3  MEM.DRID.
- mem_cc  out  3  MEM.CC.
- mem_v  out  1  MEM.V.

## Operation
- **AGEX latches** hold NPC, IR, SR1, SR2, DRID, CS[19:0], CC and V.
  - All load from the inputs on a rising edge when ld_agex=1; otherwise they hold.
  - AGEX.V loads agex_v even when it is 0, so a decode dependency stall enters the pipe as a bubble.
- **Control field decode** from AGEX.CS:
  - [0] ADDR1MUX: 0 = NPC, 1 = SR1.
  - [2:1] ADDR2MUX: 00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]), 11 = sext(IR[10:0]).
  - [3] LSHF1: shift the ADDR2 output left by 1.
  - [4] ADDRESSMUX: 0 = zext(IR[7:0])<<1, 1 = adder sum.
  - [5] SR2MUX: 0 = SR2, 1 = sext(IR[4:0]).
  - [7:6] ALUK: 00 = ADD, 01 = AND, 10 = XOR, 11 = PASSB.
  - [8] ALU.RESULTMUX: 0 = SHF, 1 = ALU.
- **Arithmetic:** 16-bit modulo; carries are discarded and there is no overflow flag.
- **SHF unit:**
  - Shifts SR1 by IR[3:0].
  - IR[5:4] selects: 00 = LSHF, x1 with IR[5]=0 = RSHFL, 11 = RSHFA (sign-filling).
  - A shift amount of 0 passes SR1 through.
- **MEM latches:**
  - When mem_stall=0, they load: the address result; the ALU/SHF result; AGEX.NPC, IR, DRID, CC; AGEX.CS[19:9]; and AGEX.V.
  - When mem_stall=1, all MEM latches hold.
  - The upstream decode logic drives ld_agex = ~mem_stall, so both latch sets freeze together.
- **Hazard outputs** are purely combinational from the AGEX latches. The AND with AGEX.V is mandatory: a bubble never asserts a hazard output.

## Timing
- Reset (rst_n=0, asynchronous): every AGEX and MEM latch clears to 0.
  - mem_v = 0, all hazard outputs = 0, all data outputs = 0x0000.
  - Reset takes priority over ld_agex and mem_stall in the same cycle.
- Latency: an instruction presented at edge N (ld_agex=1) is in AGEX during cycle N+1 and reaches the MEM latches at edge N+1, provided mem_stall=0.
- Reset asserted mid-operation discards in-flight instructions. The first valid MEM output after release requires two ld edges.
- Stall released: an instruction held in AGEX advances on the first edge with mem_stall=0. It is never duplicated or dropped.

## Configuration
- Macro: AGEX_SHF_EN.
- Defined: the full SHF unit described above is compiled in.
- Undefined: the shifter is omitted and the SHF result equals AGEX.SR1 unshifted. All other behaviour is unchanged.

## Test plan
- **ADD immediate:** ADD R1,R2,#5 with agex_sr1=0x0003, ALU.RESULTMUX=1, ALUK=00, SR2MUX=1 → after 2 edges mem_alu_result=0x0008, mem_drid=1, mem_v=1.
- **Address generation:** LDW with NPC=0x3002, ADDR1MUX=1, SR1=0x4000, ADDR2MUX=01, IR[5:0]=6'h3E, LSHF1=1 → mem_address=0x3FFC.
- **TRAP vector:** TRAP x25 with ADDRESSMUX=0 → mem_address=0x004A.
- **Shifts (AGEX_SHF_EN defined):** RSHFA with SR1=0x8010, amount 4 → 0xF801; RSHFL on the same operands → 0x0801.
  - With the macro undefined, the result is 0x8010.
- **Stall:** hold mem_stall=1 for 3 cycles with the instruction in AGEX → all mem_* outputs are unchanged.
  - Release → the instruction appears in MEM exactly once.
  - v_agex_ld_reg stays 1 throughout the stall.
- **Bubble and reset:** agex_v=0 with LD.REG=LD.CC=BR.STALL=1 → all hazard outputs stay 0.
  - Assert rst_n=0 mid-cycle → mem_v and every output drop to 0 immediately, without waiting for a clock edge.
